// File: rtl/circ_buf_acq_ctrl.sv
// Acquisition sequencer for the ADC circular-buffer write path: pre-trigger fill,
// trigger capture, post-trigger window and a small fill-descriptor FIFO.
module circ_buf_acq_ctrl #(
  parameter int ADDR_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TRIG_NUM_WIDTH = 24
) (
  input  logic                           adc_clk,
  input  logic                           reset_clk_adc,
  input  logic                           acq_enable,
  input  logic                           trig_pulse,
  input  logic [ADDR_WIDTH-1:0]          pre_trig_len,
  input  logic [ADDR_WIDTH-1:0]          post_trig_len,
  input  logic [ADDR_WIDTH-1:0]          circ_buf_wr_addr,
  input  logic                           fill_ready,
  output logic                           cbuf_wr_en,
  output logic                           acq_armed,
  output logic                           acq_busy,
  output logic                           cfg_err,
  output logic                           fill_valid,
  output logic [TRIG_NUM_WIDTH-1:0]      fill_trig_num,
  output logic [ADDR_WIDTH-1:0]          fill_trig_addr,
  output logic [$clog2(FIFO_DEPTH):0]    fill_count,
  output logic [15:0]                    trig_rejected_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = TRIG_NUM_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]     ZERO_A   = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0]     ONE_A    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]       ONE_W    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]       BUF_SIZE = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0]             ONE_P    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]               ZERO_C   = {(PW+1){1'b0}};
  localparam logic [PW:0]               ONE_C    = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0]               FULL_C   = (PW+1)'(FIFO_DEPTH);
  localparam logic [TRIG_NUM_WIDTH-1:0] ONE_T    = {{(TRIG_NUM_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL_PRE = 2'd1,
    ARMED    = 2'd2,
    POST     = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0]     pre_len, post_len, pre_cnt, post_cnt, trig_addr;
  logic [TRIG_NUM_WIDTH-1:0] trig_num;
  logic [ADDR_WIDTH:0]       cfg_sum;
  logic                      cfg_bad, pre_done, fifo_full;
  logic                      accept, reject, push, pop, latch_cfg, start_pre;

  logic [DW-1:0]             fifo_mem [FIFO_DEPTH];
  logic [DW-1:0]             push_data, head_next;
  logic [PW-1:0]             wr_ptr, rd_ptr, rd_ptr_next;
  logic [PW:0]               count_next;

  // The sum is one bit wider so a buffer-filling pre+post of exactly 2^ADDR_WIDTH is legal.
  assign cfg_sum   = {1'b0, pre_trig_len} + {1'b0, post_trig_len};
  assign cfg_bad   = cfg_sum > BUF_SIZE;
  assign pre_done  = ({1'b0, pre_cnt} + ONE_W) >= {1'b0, pre_len};
  assign fifo_full = fill_count == FULL_C;
  assign pop       = fill_valid & fill_ready;
  assign push_data = {trig_num, trig_addr};

  // Sequencer state register.
  always_ff @(posedge adc_clk) begin
    if (reset_clk_adc) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    push       = 1'b0;
    latch_cfg  = 1'b0;
    start_pre  = 1'b0;
    case (state)
      IDLE: begin
        if (acq_enable) begin
          latch_cfg = 1'b1;
          if (cfg_bad) begin
            state_next = IDLE;
          end else begin
            state_next = FILL_PRE;
            start_pre  = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      FILL_PRE: begin
        reject = trig_pulse;
        if (!acq_enable) begin
          state_next = IDLE;
        end else if (pre_done) begin
          state_next = ARMED;
        end else begin
          state_next = FILL_PRE;
        end
      end
      ARMED: begin
        if (trig_pulse && !fifo_full) begin
          accept     = 1'b1;
          state_next = POST;
        end else begin
          reject = trig_pulse;
          if (!acq_enable) begin
            state_next = IDLE;
          end else begin
            state_next = ARMED;
          end
        end
      end
      POST: begin
        reject = trig_pulse;
        if (post_cnt == ONE_A) begin
          push = 1'b1;
          if (acq_enable) begin
            state_next = FILL_PRE;
            start_pre  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = POST;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latched lengths, counters, trigger capture and status outputs.
  always_ff @(posedge adc_clk) begin
    if (reset_clk_adc) begin
      cbuf_wr_en        <= 1'b0;
      acq_armed         <= 1'b0;
      acq_busy          <= 1'b0;
      cfg_err           <= 1'b0;
      pre_len           <= ZERO_A;
      post_len          <= ZERO_A;
      pre_cnt           <= ZERO_A;
      post_cnt          <= ZERO_A;
      trig_addr         <= ZERO_A;
      trig_num          <= {TRIG_NUM_WIDTH{1'b0}};
      trig_rejected_cnt <= 16'd0;
    end else begin
      cbuf_wr_en <= (state_next != IDLE);
      acq_busy   <= (state_next != IDLE);
      acq_armed  <= (state_next == ARMED);
      if (latch_cfg) begin
        pre_len  <= pre_trig_len;
        post_len <= post_trig_len;
        if (cfg_bad) begin
          cfg_err <= 1'b1;
        end
      end
      if (start_pre) begin
        pre_cnt <= ZERO_A;
      end else if (state == FILL_PRE) begin
        pre_cnt <= pre_cnt + ONE_A;
      end
      if (accept) begin
        trig_addr <= circ_buf_wr_addr;
        post_cnt  <= (post_len == ZERO_A) ? ONE_A : post_len;
      end else if (state == POST) begin
        post_cnt <= post_cnt - ONE_A;
      end
      if (push) begin
        trig_num <= trig_num + ONE_T;
      end
      if (reject && (trig_rejected_cnt != 16'hFFFF)) begin
        trig_rejected_cnt <= trig_rejected_cnt + 16'd1;
      end
    end
  end

  // FIFO bookkeeping; an empty FIFO receiving a push forwards the new entry to the head.
  always_comb begin
    rd_ptr_next = rd_ptr;
    count_next  = fill_count;
    head_next   = {fill_trig_num, fill_trig_addr};
    if (pop) begin
      rd_ptr_next = rd_ptr + ONE_P;
    end else begin
      rd_ptr_next = rd_ptr;
    end
    if (push && !pop) begin
      count_next = fill_count + ONE_C;
    end else if (!push && pop) begin
      count_next = fill_count - ONE_C;
    end else begin
      count_next = fill_count;
    end
    if (push && (wr_ptr == rd_ptr_next)) begin
      head_next = push_data;
    end else if (count_next != ZERO_C) begin
      head_next = fifo_mem[rd_ptr_next];
    end else begin
      head_next = {fill_trig_num, fill_trig_addr};
    end
  end

  // Descriptor storage.
  always_ff @(posedge adc_clk) begin
    if (push && !reset_clk_adc) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers, occupancy and registered head.
  always_ff @(posedge adc_clk) begin
    if (reset_clk_adc) begin
      wr_ptr         <= {PW{1'b0}};
      rd_ptr         <= {PW{1'b0}};
      fill_count     <= ZERO_C;
      fill_valid     <= 1'b0;
      fill_trig_num  <= {TRIG_NUM_WIDTH{1'b0}};
      fill_trig_addr <= ZERO_A;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE_P;
      end
      rd_ptr                          <= rd_ptr_next;
      fill_count                      <= count_next;
      fill_valid                      <= (count_next != ZERO_C);
      {fill_trig_num, fill_trig_addr} <= head_next;
    end
  end

endmodule
